reg_access_ctrl: RTL and testbench

Single-port access controller that drives the 16 x 16 register file's `W`/`ON`/`ADDR`/`DATA_IN` interface and samples its tri-stated `DATA_OUT`. It accepts read-pair and write requests from the datapath over a valid/ready handshake and serialises them onto the one register-file port. Each read-pair request returns both operands in a single response beat. The block sits between the instruction decode stage and the register file.

---
 rtl/reg_access_pkg.sv | 23 ++
 rtl/reg_access_ctrl.sv | 135 +++++++++++++
 tb/tb_reg_access_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_pkg.sv
// Shared definitions for the register-file access controller.
//   state_t   : controller FSM states
//   OP_*      : request opcode encodings carried on REQ_OP
//   WORD_SIZE : default data width
//   ADDR_SIZE : default register address width
package reg_access_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 4;

  localparam logic OP_READ2 = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_RESP = 3'd3,
    ST_WR   = 3'd4,
    ST_TURN = 3'd5
  } state_t;

endpackage

// File: rtl/reg_access_ctrl.sv
// Single-port access controller for a 16 x 16 register file.
// Serialises read-pair and write requests onto the one RF port and returns
// both read operands in a single response beat.
// Ports:
//   CLK, RST                 : clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY      : request handshake
//   REQ_OP                   : OP_READ2 or OP_WRITE
//   REQ_ADDR_A/B, REQ_WDATA  : request addresses and write data
//   RSP_VALID/RSP_READY      : response handshake (reads only)
//   RSP_DATA_A/B             : operands read from ADDR_A / ADDR_B
//   RF_W, RF_ON, RF_ADDR,
//   RF_DIN, RF_DOUT          : register-file port (RF_DOUT tri-stated by RF)
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int WORD_SIZE = reg_access_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = reg_access_pkg::ADDR_SIZE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic                 REQ_OP,
  input  logic [ADDR_SIZE-1:0] REQ_ADDR_A,
  input  logic [ADDR_SIZE-1:0] REQ_ADDR_B,
  input  logic [WORD_SIZE-1:0] REQ_WDATA,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [WORD_SIZE-1:0] RSP_DATA_A,
  output logic [WORD_SIZE-1:0] RSP_DATA_B,
  output logic                 RF_W,
  output logic                 RF_ON,
  output logic [ADDR_SIZE-1:0] RF_ADDR,
  output logic [WORD_SIZE-1:0] RF_DIN,
  input  logic [WORD_SIZE-1:0] RF_DOUT
);

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] addr_b_q, addr_b_d;
  logic [ADDR_SIZE-1:0] rf_addr_q, rf_addr_d;
  logic [WORD_SIZE-1:0] rf_din_q, rf_din_d;
  logic                 rf_w_q, rf_w_d;
  logic                 rf_on_q, rf_on_d;
  logic [WORD_SIZE-1:0] rsp_a_q, rsp_a_d;
  logic [WORD_SIZE-1:0] rsp_b_q, rsp_b_d;
  logic                 accept;

  assign accept = (state_q == ST_IDLE) && REQ_VALID;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (REQ_VALID) state_d = (REQ_OP == OP_WRITE) ? ST_WR : ST_RD_A;
      ST_RD_A: state_d = ST_RD_B;
      ST_RD_B: state_d = ST_RESP;
      ST_RESP: if (RSP_READY) state_d = ST_IDLE;
      ST_WR:   state_d = ST_TURN;
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. The RF strobes are registered from the next state so they
  // are glitch-free and stable for the whole cycle, as the RF writes on
  // either clock level change.
  always_comb begin
    addr_b_d  = addr_b_q;
    rf_addr_d = rf_addr_q;
    rf_din_d  = rf_din_q;
    rsp_a_d   = rsp_a_q;
    rsp_b_d   = rsp_b_q;
    rf_on_d   = (state_d == ST_RD_A) || (state_d == ST_RD_B) || (state_d == ST_WR);
    rf_w_d    = (state_d == ST_WR);

    if (accept) begin
      rf_addr_d = REQ_ADDR_A;
      if (REQ_OP == OP_WRITE) begin
        rf_din_d = REQ_WDATA;
      end else begin
        addr_b_d = REQ_ADDR_B;
      end
    end

    // Each read cycle samples RF_DOUT at its closing edge.
    if (state_q == ST_RD_A) begin
      rsp_a_d   = RF_DOUT;
      rf_addr_d = addr_b_q;
    end
    if (state_q == ST_RD_B) begin
      rsp_b_d = RF_DOUT;
    end
  end

  // Capture and RF port registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_b_q  <= '0;
      rf_addr_q <= '0;
      rf_din_q  <= '0;
      rf_w_q    <= 1'b0;
      rf_on_q   <= 1'b0;
      rsp_a_q   <= '0;
      rsp_b_q   <= '0;
    end else begin
      addr_b_q  <= addr_b_d;
      rf_addr_q <= rf_addr_d;
      rf_din_q  <= rf_din_d;
      rf_w_q    <= rf_w_d;
      rf_on_q   <= rf_on_d;
      rsp_a_q   <= rsp_a_d;
      rsp_b_q   <= rsp_b_d;
    end
  end

  // Handshake outputs are pure state decodes.
  assign REQ_READY  = (state_q == ST_IDLE);
  assign RSP_VALID  = (state_q == ST_RESP);
  assign RSP_DATA_A = rsp_a_q;
  assign RSP_DATA_B = rsp_b_q;
  assign RF_W       = rf_w_q;
  assign RF_ON      = rf_on_q;
  assign RF_ADDR    = rf_addr_q;
  assign RF_DIN     = rf_din_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: a behavioural 16 x 16 register
// file acts as responder, and a word-array reference model predicts every
// read response and port-level timing.
module tb_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_op;
  logic [3:0]  req_addr_a, req_addr_b;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data_a, rsp_data_b;
  logic        rf_w, rf_on;
  logic [3:0]  rf_addr;
  logic [15:0] rf_din;
  wire  [15:0] rf_dout;

  // Responder register file
  logic [15:0] rf_mem [16];
  logic        rf_clear;

  // Reference model
  logic [15:0] ref_mem [16];
  bit          unk_valid;
  logic [3:0]  unk_addr;
  logic [15:0] unk_new;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_OP(req_op),
    .REQ_ADDR_A(req_addr_a), .REQ_ADDR_B(req_addr_b), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
    .RSP_DATA_A(rsp_data_a), .RSP_DATA_B(rsp_data_b),
    .RF_W(rf_w), .RF_ON(rf_on), .RF_ADDR(rf_addr), .RF_DIN(rf_din),
    .RF_DOUT(rf_dout)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 16'h0101) ^ 16'h5A00;
  endfunction

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= init_val(i);
    end else if (rf_on && rf_w) begin
      rf_mem[rf_addr] <= rf_din;
    end
  end

  assign rf_dout = (rf_on && !rf_w) ? rf_mem[rf_addr] : 16'hzzzz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk("idle_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic scramble();
    req_addr_a = 4'($urandom);
    req_addr_b = 4'($urandom);
    req_wdata  = 16'($urandom);
    req_op     = 1'($urandom);
  endtask

  // Expected read value; a register whose write was cut by reset may hold
  // either its old or its new value.
  function automatic logic [15:0] exp_rd(input logic [3:0] a, input logic [15:0] got);
    if (unk_valid && a == unk_addr && got == unk_new) return unk_new;
    return ref_mem[a];
  endfunction

  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    wait_idle();
    req_valid = 1'b1; req_op = 1'b1; req_addr_a = a;
    req_addr_b = 4'($urandom); req_wdata = d;
    step();
    req_valid = 1'b0; scramble();
    chk("wr_w", 32'(rf_w), 32'd1);
    chk("wr_on", 32'(rf_on), 32'd1);
    chk("wr_addr", 32'(rf_addr), 32'(a));
    chk("wr_din", 32'(rf_din), 32'(d));
    chk("wr_busy", 32'(req_ready), 32'd0);
    ref_mem[a] = d;
    if (unk_valid && unk_addr == a) unk_valid = 1'b0;
    step();
    chk("turn_w", 32'(rf_w), 32'd0);
    chk("turn_on", 32'(rf_on), 32'd0);
    chk("turn_rdy", 32'(req_ready), 32'd0);
    chk("turn_addr", 32'(rf_addr), 32'(a));
    step();
    chk("wr_done_rdy", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b, input int hold);
    logic [15:0] ea, eb;
    wait_idle();
    req_valid = 1'b1; req_op = 1'b0; req_addr_a = a; req_addr_b = b;
    req_wdata = 16'($urandom);
    rsp_ready = (hold == 0);
    step();
    req_valid = 1'b0; scramble();
    chk("rda_on", 32'(rf_on), 32'd1);
    chk("rda_w", 32'(rf_w), 32'd0);
    chk("rda_addr", 32'(rf_addr), 32'(a));
    chk("rda_rsp", 32'(rsp_valid), 32'd0);
    step();
    chk("rdb_on", 32'(rf_on), 32'd1);
    chk("rdb_w", 32'(rf_w), 32'd0);
    chk("rdb_addr", 32'(rf_addr), 32'(b));
    step();
    ea = exp_rd(a, rsp_data_a);
    eb = exp_rd(b, rsp_data_b);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_a", 32'(rsp_data_a), 32'(ea));
    chk("rsp_b", 32'(rsp_data_b), 32'(eb));
    chk("rsp_on", 32'(rf_on), 32'd0);
    chk("rsp_rdy", 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom);
      step();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_a", 32'(rsp_data_a), 32'(ea));
      chk("bp_b", 32'(rsp_data_b), 32'(eb));
      chk("bp_rdy", 32'(req_ready), 32'd0);
      chk("bp_on", 32'(rf_on), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("hs_valid", 32'(rsp_valid), 32'd0);
    chk("hs_rdy", 32'(req_ready), 32'd1);
    if (unk_valid && (a == unk_addr || b == unk_addr)) begin
      ref_mem[unk_addr] = (a == unk_addr) ? rsp_data_a : rsp_data_b;
      unk_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_rdy", 32'(req_ready), 32'd1);
      chk("idle_on", 32'(rf_on), 32'd0);
      chk("idle_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_a"}, 32'(rsp_data_a), 32'd0);
    chk({tag, "_b"}, 32'(rsp_data_b), 32'd0);
    chk({tag, "_w"}, 32'(rf_w), 32'd0);
    chk({tag, "_on"}, 32'(rf_on), 32'd0);
    chk({tag, "_addr"}, 32'(rf_addr), 32'd0);
    chk({tag, "_din"}, 32'(rf_din), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rf_clear = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    scramble();
    unk_valid = 1'b0; unk_addr = '0; unk_new = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    repeat (3) step();
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0; rf_clear = 1'b0;
    step();
    chk("post_reset_rdy", 32'(req_ready), 32'd1);

    // Write then read back the same register on both ports
    do_write(4'd3, 16'hBEEF);
    do_read(4'd3, 4'd3, 0);

    // Two distinct registers
    do_write(4'd1, 16'h1234);
    do_write(4'd2, 16'hABCD);
    do_read(4'd1, 4'd2, 0);

    // Response backpressure
    do_read(4'd2, 4'd1, 5);

    // Back-to-back traffic
    for (int i = 1; i <= 15; i++) do_write(4'(16 - i), 16'(i));
    for (int p = 0; p < 8; p++) do_read(4'(2 * p), 4'(2 * p + 1), 0);

    // Reset while a response is pending
    wait_idle();
    req_valid = 1'b1; req_op = 1'b0; req_addr_a = 4'd5; req_addr_b = 4'd6;
    rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step(); step();
    chk("pre_rst_rsp", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_resp");
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b1;
    step();
    chk("rst_resp_rdy", 32'(req_ready), 32'd1);
    chk("rst_resp_on", 32'(rf_on), 32'd0);
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);

    // Reset while a write is on the port
    wait_idle();
    req_valid = 1'b1; req_op = 1'b1; req_addr_a = 4'd9; req_wdata = 16'hC0DE;
    step();
    req_valid = 1'b0;
    chk("rst_wr_w_before", 32'(rf_w), 32'd1);
    unk_valid = 1'b1; unk_addr = 4'd9; unk_new = 16'hC0DE;
    #2 rst = 1'b1;
    #1 chk("rst_wr_w", 32'(rf_w), 32'd0);
    chk("rst_wr_on", 32'(rf_on), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    do_read(4'd9, 4'd0, 0);

    // Randomised traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(1, 0) == 1)
        do_write(4'($urandom), 16'($urandom));
      else
        do_read(4'($urandom), 4'($urandom), int'($urandom_range(3, 0)));
      idle(int'($urandom_range(2, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
